// File: rtl/bcd_ascii_serializer.sv
// bcd_ascii_serializer
// Captures one BCD nonce and streams it out as ASCII decimal bytes, most
// significant digit first, over a valid/ready byte interface. Digit codes
// 0xA-0xF are replaced by BAD_CHAR and flagged on tx_error for the frame.
// Optional feature macro: BCD_ASCII_LZ_SUPPRESS_EN (leading-zero suppression).
module bcd_ascii_serializer #(
   parameter int          DIGITS   = 15,
   parameter logic [7:0]  BAD_CHAR = 8'h3F
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DIGITS*4-1:0]   rx_nonce,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  tx_last,
   output logic                  tx_error
);

   localparam int W = DIGITS * 4;

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t       state_q, state_n;
   logic [W-1:0] shift_q, shift_n;
   logic [3:0]   cnt_q, cnt_n;
   logic [7:0]   data_n;
   logic         valid_n, last_n, error_n;

   logic [W-1:0] load_val;
   logic [3:0]   load_cnt;
   logic         any_bad;
   logic [W-1:0] shifted;

   // Map one BCD digit to its ASCII character, substituting BAD_CHAR for 0xA-0xF.
   function automatic logic [7:0] to_ascii(input logic [3:0] d);
      return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : BAD_CHAR;
   endfunction

   // Capture preparation: illegal-digit flag, initial counter and register image.
   // NOTE: every variable driven here gets a value before any branch, so no latch is inferred.
   always_comb begin
      any_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (rx_nonce[i*4 +: 4] > 4'd9) any_bad = 1'b1;
      end
`ifdef BCD_ASCII_LZ_SUPPRESS_EN
      // Highest nonzero digit wins; an all-zero nonce leaves index 0 so one '0' is sent.
      load_cnt = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (rx_nonce[i*4 +: 4] != 4'd0) load_cnt = 4'(i);
      end
      load_val = rx_nonce << {4'(DIGITS-1) - load_cnt, 2'b00};
`else
      load_cnt = 4'(DIGITS-1);
      load_val = rx_nonce;
`endif
   end

   // Next digit image after one byte has been accepted.
   assign shifted  = shift_q << 4;

   // Ready to capture exactly when no frame is in flight.
   assign rx_ready = (state_q == IDLE);

   // Next-state and next-output logic for the capture/send FSM.
   always_comb begin
      state_n = state_q;
      shift_n = shift_q;
      cnt_n   = cnt_q;
      data_n  = tx_data;
      valid_n = tx_valid;
      last_n  = tx_last;
      error_n = tx_error;
      case (state_q)
         IDLE: begin
            if (rx_valid) begin
               state_n = SEND;
               shift_n = load_val;
               cnt_n   = load_cnt;
               data_n  = to_ascii(load_val[W-1 -: 4]);
               valid_n = 1'b1;
               last_n  = (load_cnt == 4'd0);
               error_n = any_bad;
            end
         end
         SEND: begin
            // Outputs hold their registered values until the byte is accepted.
            if (tx_ready) begin
               if (cnt_q != 4'd0) begin
                  shift_n = shifted;
                  cnt_n   = cnt_q - 4'd1;
                  data_n  = to_ascii(shifted[W-1 -: 4]);
                  last_n  = (cnt_q == 4'd1);
               end else begin
                  state_n = IDLE;
                  valid_n = 1'b0;
                  last_n  = 1'b0;
                  error_n = 1'b0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State and output registers; async reset drops tx_valid mid-frame at once.
   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         cnt_q    <= 4'd0;
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
         tx_last  <= 1'b0;
         tx_error <= 1'b0;
      end else begin
         state_q  <= state_n;
         shift_q  <= shift_n;
         cnt_q    <= cnt_n;
         tx_data  <= data_n;
         tx_valid <= valid_n;
         tx_last  <= last_n;
         tx_error <= error_n;
      end
   end

endmodule

// File: tb/tb_bcd_ascii_serializer.sv
// Directed bench for bcd_ascii_serializer (DIGITS=15). Expected byte streams
// follow the macro BCD_ASCII_LZ_SUPPRESS_EN when it is defined for the build.
module tb_bcd_ascii_serializer;

   localparam int D = 15;
   localparam bit LZ =
`ifdef BCD_ASCII_LZ_SUPPRESS_EN
      1'b1;
`else
      1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [D*4-1:0] rx_nonce;
   logic          rx_valid;
   logic          rx_ready;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          tx_last;
   logic          tx_error;

   int n_checks = 0;
   int n_err    = 0;

   bcd_ascii_serializer #(.DIGITS(D), .BAD_CHAR(8'h3F)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_nonce (rx_nonce),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_last  (tx_last),
      .tx_error (tx_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a nonce for exactly one capture edge; returns at the following negedge.
   task automatic launch(input logic [D*4-1:0] nonce);
      @(negedge clk);
      rx_nonce = nonce;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   // Receive one frame starting at the negedge after capture and check every byte.
   task automatic collect(input logic [D*4-1:0] nonce, input bit stall, input logic exp_err);
      logic [7:0] exp_q[$];
      logic [3:0] d;
      logic [7:0] prev_data;
      logic       prev_last;
      bit         started, prev_stall, done;
      int         idx, cyc, len;
      started = 1'b0;
      for (int i = D-1; i >= 0; i--) begin
         d = nonce[i*4 +: 4];
         if (!(LZ && !started && d == 4'd0 && i != 0)) begin
            started = 1'b1;
            exp_q.push_back((d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F);
         end
      end
      len = exp_q.size();
      idx = 0; cyc = 0; done = 1'b0; prev_stall = 1'b0;
      prev_data = 8'h00; prev_last = 1'b0;
      chk("first_byte_latency", tx_valid, 1);
      while (!done && cyc < 200) begin
         tx_ready = stall ? (cyc % 3 == 0) : 1'b1;
         if (tx_valid) begin
            if (prev_stall) begin
               chk("stall_data_stable", tx_data, prev_data);
               chk("stall_last_stable", tx_last, prev_last);
            end
            chk("rx_ready_in_send", rx_ready, 0);
            chk("tx_error_frame", tx_error, exp_err);
            if (tx_ready && idx < len) begin
               chk("tx_data", tx_data, exp_q[idx]);
               chk("tx_last", tx_last, (idx == len-1));
               idx++;
               if (tx_last || idx == len) done = 1'b1;
            end
            prev_stall = !tx_ready;
            prev_data  = tx_data;
            prev_last  = tx_last;
         end else begin
            chk("tx_valid_in_frame", tx_valid, 1);
            done = 1'b1;
         end
         cyc++;
         @(negedge clk);
      end
      chk("byte_count", idx, len);
      if (!stall) chk("consecutive_cycles", cyc, len);
      chk("idle_tx_valid", tx_valid, 0);
      chk("idle_tx_last", tx_last, 0);
      chk("idle_tx_error", tx_error, 0);
      chk("idle_rx_ready", rx_ready, 1);
   endtask

   initial begin
      int hs;
      rst = 1'b1; rx_valid = 1'b0; rx_nonce = '0; tx_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_rx_ready", rx_ready, 1);
      chk("reset_tx_valid", tx_valid, 0);
      chk("reset_tx_last", tx_last, 0);
      chk("reset_tx_data", tx_data, 8'h00);
      chk("reset_tx_error", tx_error, 0);
      rst = 1'b0;
      @(negedge clk);

      // Short number, ready always high.
      launch(60'h000000000000123);
      collect(60'h000000000000123, 1'b0, 1'b0);

      // All nines under a 1,0,0 ready pattern.
      launch(60'h999999999999999);
      collect(60'h999999999999999, 1'b1, 1'b0);

      // All zeros.
      launch(60'h0);
      collect(60'h0, 1'b0, 1'b0);

      // Illegal digit 3 = 0xB, then a clean frame.
      launch(60'h12345678901B234);
      collect(60'h12345678901B234, 1'b0, 1'b1);
      launch(60'h000000000000123);
      collect(60'h000000000000123, 1'b0, 1'b0);

      // rx_valid held across nonce A then B: B ignored during A, captured right after.
      @(negedge clk);
      rx_nonce = 60'h111111111111111;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_nonce = 60'h222222222222222;
      collect(60'h111111111111111, 1'b0, 1'b0);
      @(negedge clk);
      rx_valid = 1'b0;
      collect(60'h222222222222222, 1'b0, 1'b0);

      // Asynchronous reset after the fifth handshake.
      launch(60'h987654321012345);
      tx_ready = 1'b1;
      hs = 0;
      for (int c = 0; c < 20 && hs < 5; c++) begin
         if (tx_valid) hs++;
         @(negedge clk);
      end
      chk("pre_reset_handshakes", hs, 5);
      chk("pre_reset_tx_valid", tx_valid, 1);
      rst = 1'b1;
      #1;
      chk("async_reset_tx_valid", tx_valid, 0);
      chk("async_reset_tx_last", tx_last, 0);
      chk("async_reset_rx_ready", rx_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_rx_ready", rx_ready, 1);
      chk("post_reset_tx_valid", tx_valid, 0);
      launch(60'h987654321012345);
      collect(60'h987654321012345, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
